// File: rtl/stream_mux_rr.sv
// Registered N:1 stream multiplexer with valid/ready handshakes.
// Supports fixed-address selection and round-robin arbitration.
module stream_mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          address,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             valid_q, valid_d;

    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic [SEL_W:0]   rr_idx;
    logic             can_load;
    logic             xfer_in;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_idx  = '0;
        if (!mode) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (address == SEL_W'(i) && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end else begin
            // Scan farthest-first so the channel closest to ptr is written last and wins.
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                rr_idx = {1'b0, ptr_q} + (SEL_W+1)'(k);
                if (rr_idx >= (SEL_W+1)'(CHANNELS))
                    rr_idx = rr_idx - (SEL_W+1)'(CHANNELS);
                if (in_valid[rr_idx[SEL_W-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = rr_idx[SEL_W-1:0];
                end
            end
        end
    end

    assign can_load = !valid_q || out_ready;
    assign xfer_in  = gnt_vld && can_load;
    assign in_ready = (xfer_in && !reset) ? (CHANNELS'(1) << gnt_idx) : '0;

    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (xfer_in) begin
            data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
            chan_d  = gnt_idx;
            valid_d = 1'b1;
            if (mode)
                ptr_d = (gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: a 4-channel instance and a 3-channel
// instance for the non-power-of-two wrap.
module tb_stream_mux_rr;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode, out_ready, out_valid;
    logic [1:0]  address, out_chan;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [7:0]  out_data;

    logic        mode3, out_ready3, out_valid3;
    logic [1:0]  address3, out_chan3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [7:0]  out_data3;

    exp_t sbq[$];
    exp_t sbq3[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut4 (
        .clk(clk), .reset(reset), .mode(mode), .address(address),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clk(clk), .reset(reset), .mode(mode3), .address(address3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    function automatic logic [7:0] dat(input int i);
        return 8'(8'h11 * (i + 1));
    endfunction

    // Retire the held word if the consumer takes it this cycle, record any
    // expected transfer in, then advance to just after the next rising edge.
    task automatic cycle(input bit push, input int ch);
        if (sbq.size() != 0 && out_ready) void'(sbq.pop_front());
        if (push) sbq.push_back({2'(ch), dat(ch)});
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 1'b0; address = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        mode3 = 1'b0; address3 = 2'd0; in_valid3 = 3'b0; out_ready3 = 1'b1;
        in_data3 = {8'h33, 8'h22, 8'h11};
        #1;
        total++;
        if ({out_valid, out_chan, out_data} !== 11'b0) begin
            bad++; $display("FAIL reset_out: got v=%b ch=%0d d=%h want 0/0/00", out_valid, out_chan, out_data);
        end
        total++;
        if (in_ready !== 4'b0) begin
            bad++; $display("FAIL reset_ready: got %b want 0000", in_ready);
        end
        in_valid = 4'h0;
        #2 reset = 1'b0;
    endtask

    task automatic test_fixed_sweep();
        in_valid = 4'hF; out_ready = 1'b1; mode = 1'b0;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            total++;
            if (in_ready !== (4'b0001 << a)) begin
                bad++; $display("FAIL fixed_ready[%0d]: got %b want %b", a, in_ready, 4'b0001 << a);
            end
            cycle(1'b1, a);
            total++;
            if (sbq.size() == 0 ? out_valid !== 1'b0 : {out_valid, out_chan, out_data} !== {1'b1, sbq[0]}) begin
                bad++; $display("FAIL fixed_out[%0d]: got v=%b ch=%0d d=%h", a, out_valid, out_chan, out_data);
            end
        end
    endtask

    task automatic test_invalid_select();
        address = 2'd2; in_valid = 4'b1011;
        #1;
        total++;
        if (in_ready !== 4'b0) begin
            bad++; $display("FAIL inv_ready: got %b want 0000", in_ready);
        end
        cycle(1'b0, 0);
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'h44) begin
            bad++; $display("FAIL inv_drain: got v=%b d=%h want v=0 d=44", out_valid, out_data);
        end
        in_valid = 4'hF;
        #1;
        total++;
        if (in_ready !== 4'b0100) begin
            bad++; $display("FAIL inv_recover_ready: got %b want 0100", in_ready);
        end
        cycle(1'b1, 2);
        total++;
        if (sbq.size() == 0 ? out_valid !== 1'b0 : {out_valid, out_chan, out_data} !== {1'b1, sbq[0]}) begin
            bad++; $display("FAIL inv_recover_out: got v=%b ch=%0d d=%h", out_valid, out_chan, out_data);
        end
    endtask

    task automatic test_rr_fair();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int ch;
            if (i == 8) in_valid = 4'b1010;
            ch = (i < 8) ? (i % 4) : ((i % 2) ? 3 : 1);
            #1;
            total++;
            if (in_ready !== (4'b0001 << ch)) begin
                bad++; $display("FAIL rr_ready[%0d]: got %b want %b", i, in_ready, 4'b0001 << ch);
            end
            cycle(1'b1, ch);
            total++;
            if (sbq.size() == 0 ? out_valid !== 1'b0 : {out_valid, out_chan, out_data} !== {1'b1, sbq[0]}) begin
                bad++; $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%h want ch=%0d", i, out_valid, out_chan, out_data, ch);
            end
        end
    endtask

    task automatic test_backpressure();
        in_valid = 4'b0100;
        #1;
        cycle(1'b1, 2);
        total++;
        if (sbq.size() == 0 ? out_valid !== 1'b0 : {out_valid, out_chan, out_data} !== {1'b1, sbq[0]}) begin
            bad++; $display("FAIL bp_load: got v=%b ch=%0d d=%h want ch=2", out_valid, out_chan, out_data);
        end
        out_ready = 1'b0; in_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (in_ready !== 4'b0) begin
                bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, in_ready);
            end
            cycle(1'b0, 0);
            total++;
            if (sbq.size() == 0 ? out_valid !== 1'b0 : {out_valid, out_chan, out_data} !== {1'b1, sbq[0]}) begin
                bad++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%h", i, out_valid, out_chan, out_data);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            int ch;
            ch = (i == 0) ? 3 : 0;
            #1;
            total++;
            if (in_ready !== (4'b0001 << ch)) begin
                bad++; $display("FAIL bp_release_ready[%0d]: got %b want %b", i, in_ready, 4'b0001 << ch);
            end
            cycle(1'b1, ch);
            total++;
            if (sbq.size() == 0 ? out_valid !== 1'b0 : {out_valid, out_chan, out_data} !== {1'b1, sbq[0]}) begin
                bad++; $display("FAIL bp_release_out[%0d]: got v=%b ch=%0d d=%h", i, out_valid, out_chan, out_data);
            end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 4'h0;
        #2 reset = 1'b1;
        #1;
        total++;
        if ({out_valid, out_chan, out_data} !== 11'b0) begin
            bad++; $display("FAIL areset_out: got v=%b ch=%0d d=%h want 0/0/00", out_valid, out_chan, out_data);
        end
        in_valid = 4'hF; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0) begin
            bad++; $display("FAIL areset_ready: got %b want 0000", in_ready);
        end
        sbq.delete();
        sbq3.delete();
        in_valid = 4'h0;
        #2 reset = 1'b0;
        in_valid = 4'hF; mode = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0001) begin
            bad++; $display("FAIL areset_ptr: got %b want 0001", in_ready);
        end
        cycle(1'b1, 0);
        total++;
        if (sbq.size() == 0 ? out_valid !== 1'b0 : {out_valid, out_chan, out_data} !== {1'b1, sbq[0]}) begin
            bad++; $display("FAIL areset_first: got v=%b ch=%0d d=%h", out_valid, out_chan, out_data);
        end
        in_valid = 4'h0;
    endtask

    task automatic test_np2_wrap();
        mode3 = 1'b1; in_valid3 = 3'b111; out_ready3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (in_ready3 !== (3'b001 << (i % 3))) begin
                bad++; $display("FAIL np2_ready[%0d]: got %b want %b", i, in_ready3, 3'b001 << (i % 3));
            end
            sbq3.push_back({2'(i % 3), dat(i % 3)});
            @(posedge clk); #1;
            total++;
            if ({out_valid3, out_chan3, out_data3} !== {1'b1, sbq3[0]}) begin
                bad++; $display("FAIL np2_out[%0d]: got v=%b ch=%0d d=%h want ch=%0d", i, out_valid3, out_chan3, out_data3, i % 3);
            end
            void'(sbq3.pop_front());
        end
        mode3 = 1'b0; address3 = 2'd3;
        #1;
        total++;
        if (in_ready3 !== 3'b0) begin
            bad++; $display("FAIL np2_addr3_ready: got %b want 000", in_ready3);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid3 !== 1'b0) begin
            bad++; $display("FAIL np2_addr3_out: got v=%b want 0", out_valid3);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_sweep();
        test_invalid_select();
        test_rr_fair();
        test_backpressure();
        test_async_reset();
        test_np2_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
